// File: rtl/ifm_buf_pkg.sv
// Shared constants for the ping-pong IFM buffers and their write/read bridges.
// Also holds the tile-end event handed from the fill counter to the flag logic.
package ifm_buf_pkg;
   localparam int BANK_W   = 128;
   localparam int ADDR_W   = 10;
   localparam int DEPTH    = 1024;
   localparam int DEF_SIZE = 8;

   typedef struct packed {
      logic en;
      logic part;
   } tile_evt_t;

   // cfg_words of 0 and 1024 both wrap to a last address of DEPTH-1.
   function automatic logic [ADDR_W-1:0] words_to_last(input logic [10:0] words);
      logic [10:0] m;
      m = words - 11'd1;
      return m[ADDR_W-1:0];
   endfunction
endpackage

// File: rtl/ifm_pp_flags.sv
// Full/empty flags of both parts, the reader-side part mirror and the switch pulse.
// rd_sel follows the bridge's buf_sel: it flips on the edge where buf_switch is high.
module ifm_pp_flags
   import ifm_buf_pkg::*;
(
   input  logic       clock,
   input  logic       rst,
   input  logic       loop_end,
   input  tile_evt_t  set_evt,
   input  logic       rd_release,
   output logic [1:0] full,
   output logic       rd_sel,
   output logic       buf_switch,
   output logic       data_ready
);
   logic [1:0] full_nxt;
   logic       sw_cond;

   always_comb begin
      full_nxt = full;
      if (rd_release && full[rd_sel]) full_nxt[rd_sel] = 1'b0;
      if (set_evt.en) full_nxt[set_evt.part] = 1'b1;
   end

   // Evaluated on next-state flags so a release at t yields buf_switch at t+1.
   assign sw_cond    = !full_nxt[rd_sel] && full_nxt[!rd_sel] && !buf_switch;
   assign data_ready = full[rd_sel] && !buf_switch;

   always_ff @(posedge clock) begin
      if (rst || loop_end) begin
         full       <= '0;
         rd_sel     <= 1'b0;
         buf_switch <= 1'b0;
      end else begin
         full       <= full_nxt;
         buf_switch <= sw_cond;
         if (buf_switch) rd_sel <= !rd_sel;
      end
   end
endmodule

// File: rtl/ifm_buf_writer.sv
// Write-side controller for the ping-pong IFM buffers: fills the empty part with a
// tile of pixel words, writing both img2col copies, and hands full parts to the reader.
module ifm_buf_writer
   import ifm_buf_pkg::*;
#(
   parameter int SIZE = DEF_SIZE
) (
   input  logic                     clock,
   input  logic                     rst,
   input  logic                     loop_end,
   input  logic [10:0]              cfg_words,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [SIZE*BANK_W-1:0]   in_data,
   input  logic [SIZE-1:0]          in_mask,
   output logic [SIZE-1:0]          wr_en_part0_0,
   output logic [SIZE-1:0]          wr_en_part0_1,
   output logic [SIZE-1:0]          wr_en_part1_0,
   output logic [SIZE-1:0]          wr_en_part1_1,
   output logic [SIZE*ADDR_W-1:0]   wr_addr,
   output logic [SIZE*BANK_W-1:0]   wr_data,
   input  logic                     rd_release,
   output logic                     data_ready,
   output logic                     buf_switch
);
   logic [1:0]        full;
   logic              rd_sel;
   logic              wr_sel;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] last_q;
   logic [ADDR_W-1:0] last;
   logic              accept;
   logic              tile_end;
   tile_evt_t         evt_q;

   assign in_ready = !full[wr_sel] && !rst && !loop_end;
   assign accept   = in_valid && in_ready;
   // The first word of a tile uses the live cfg_words; later words use the latch.
   assign last     = (addr == '0) ? words_to_last(cfg_words) : last_q;
   assign tile_end = accept && (addr == last);

   always_ff @(posedge clock) begin
      if (rst || loop_end) begin
         addr          <= '0;
         last_q        <= '0;
         wr_sel        <= 1'b0;
         evt_q         <= '0;
         wr_en_part0_0 <= '0;
         wr_en_part0_1 <= '0;
         wr_en_part1_0 <= '0;
         wr_en_part1_1 <= '0;
         wr_addr       <= '0;
         wr_data       <= '0;
      end else begin
         // Full is raised one cycle after the last write so the memory has committed it.
         evt_q.en      <= tile_end;
         evt_q.part    <= wr_sel;
         wr_en_part0_0 <= (accept && !wr_sel) ? in_mask : '0;
         wr_en_part0_1 <= (accept && !wr_sel) ? in_mask : '0;
         wr_en_part1_0 <= (accept &&  wr_sel) ? in_mask : '0;
         wr_en_part1_1 <= (accept &&  wr_sel) ? in_mask : '0;
         if (accept) begin
            wr_addr <= {SIZE{addr}};
            wr_data <= in_data;
            if (addr == '0) last_q <= last;
            addr <= tile_end ? '0 : addr + 1'b1;
            if (tile_end) wr_sel <= !wr_sel;
         end
      end
   end

   ifm_pp_flags u_flags (
      .clock      (clock),
      .rst        (rst),
      .loop_end   (loop_end),
      .set_evt    (evt_q),
      .rd_release (rd_release),
      .full       (full),
      .rd_sel     (rd_sel),
      .buf_switch (buf_switch),
      .data_ready (data_ready)
   );
endmodule

// File: doc/ifm_buf_writer.md
# ifm_buf_writer

Write-side controller for the ping-pong input-feature-map buffers. It accepts a stream of 1024-bit pixel words and writes each word into both img2col sub-buffers (`_0` and `_1`) of whichever part (part0/part1) is empty. It tracks the full/empty state of both parts and pulses `buf_switch` to the read-side bridge when the reader's part has been released and the other part holds a complete tile. It mirrors the bridge's `buf_sel` exactly, so writer and reader never touch the same part at the same time.

## Interface

Parameters:
- `SIZE`, default 8: number of banks per buffer; each bank is 128 bits wide with a 10-bit address.

Ports:
- `clock`  in  1  single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `loop_end`  in  1  sync clear; the same signal drives the bridge.
- `cfg_words`  in  11  words per tile, legal 1..1024; 0 means 1024; latched on the first word of each tile.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  writer can accept a word.
- `in_data`  in  1024  pixel word.
- `in_mask`  in  SIZE  bank write mask for this word.
- `wr_en_part0_0`, `wr_en_part0_1`, `wr_en_part1_0`, `wr_en_part1_1`  out  SIZE  per-bank write enables.
- `wr_addr`  out  SIZE*10  address replicated per bank (shared by all four buffers).
- `wr_data`  out  1024  write data (shared).
- `rd_release`  in  1  one-cycle pulse from the reader: done with part `rd_sel`.
- `data_ready`  out  1  the reader's current part holds a full tile.
- `buf_switch`  out  1  one-cycle pulse to the bridge; toggles the read part.

## Operation

State:
- `full[1:0]`: one flag per part.
- `wr_sel`: part being filled.
- `rd_sel`: mirror of the bridge's `buf_sel`.
- `addr[9:0]`: word counter within the current tile.
- `last_q[9:0]`: latched value `cfg_words-1`, truncated to 10 bits.

Fill:
- `in_ready = !full[wr_sel] && !rst && !loop_end`.
- A word is accepted when `in_valid && in_ready`.
- The accepted word is written at `addr` into both `partX_0` and `partX_1`, where X = `wr_sel`; the enable is `in_mask`.
- Enables of the other part are 0.
- `addr` increments on each accept.

Tile end (accept while `addr == last`):
- `addr` ← 0.
- `wr_sel` toggles.
- `full[old wr_sel]` is set one cycle after the final write (see Timing).

Release:
- `rd_release` with `full[rd_sel]=1` clears `full[rd_sel]`.
- `rd_release` with `full[rd_sel]=0` is ignored.

Switch:
- Condition: `!full[rd_sel] && full[~rd_sel] && !buf_switch`.
- `buf_switch` is registered from this condition.
- `rd_sel` toggles on the edge where `buf_switch=1`, matching the bridge.

Ready:
- `data_ready = full[rd_sel] && !buf_switch`.

Reset / `loop_end`:
- `full`=0, `wr_sel`=0, `rd_sel`=0, `addr`=0, `buf_switch`=0, all `wr_en`=0, `in_ready`=0 during that cycle.
- A partial tile is discarded.
- `wr_addr` and `wr_data` reset to 0.

## Timing

- Write latency: a word accepted in cycle t appears on `wr_en`/`wr_addr`/`wr_data` in cycle t+1.
  - All write outputs are registered.
- Last word accepted at t: `full` is set at the end of t+1 and is visible at t+2.
  - `data_ready` can rise at t+2 at the earliest; the memory write has committed by then.
- Once the last word is accepted at t, `in_ready` for the next part is evaluated at t+1 against the new `wr_sel`.
  - A back-to-back tile costs 0 bubbles if that part is empty.
- `rd_release` at t clears the flag at the end of t.
  - If the other part is full, `buf_switch=1` at t+1 and `rd_sel` flips at the end of t+1.
- Simultaneous events in the same cycle:
  - `rd_release` and tile-end on different parts: both take effect.
  - `loop_end` and any other event: `loop_end` wins.
- Both parts full: `in_ready=0` until a release followed by a switch.

## Structure

- Shared package `ifm_buf_pkg`: `BANK_W=128`, `ADDR_W=10`, `DEPTH=1024`, default `SIZE=8`.
  - The bridge uses the same constants.
- One sub-module, `ifm_pp_flags`, holds `full[1:0]`, `rd_sel`, `buf_switch`, `data_ready` and the release/switch logic.
- The top level holds the fill counter, the `cfg_words` latch and the write-port registers.

## Test plan

- **Single tile:** `cfg_words=4`, 4 words, mask 0xFF → `wr_en_part0_0`/`_0_1`=0xFF with addr 0..3 at t+1..t+4; part1 enables 0; `data_ready` rises 2 cycles after the last accept; `buf_switch` stays 0.
- **Ping-pong:** fill tile A (part0), then tile B (part1); pulse `rd_release` → `buf_switch` high exactly 1 cycle, next cycle; `rd_sel`=1; `data_ready`=1 a cycle after the pulse.
- **Back-pressure:** fill both parts, keep `in_valid`=1 → `in_ready`=0 until release+switch; then the third tile writes part0 at addr 0.
- **Early release:** release part0 before tile B completes → no switch; `buf_switch` fires 1 cycle after `full[1]` sets.
- **`loop_end` mid-tile:** assert after 2 of 4 words → next word writes part0 addr 0; all flags 0; `buf_switch` never fires.
- **Boundaries:** `cfg_words=0` → 1024 writes (addr 0..1023) before the tile completes; `cfg_words=1` → full after a single word; `rd_release` with an empty part is ignored.
